// File: rtl/change_dispenser.sv
// Coin-return transmitter: pays out a latched change amount as a serial train of
// single-coin pulses, greedy quarters -> dimes -> nickels, with fixed pulse/gap timing.
module change_dispenser #(
  parameter int AMT_W        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             nickel,
  output logic             dime,
  output logic             quarter,
  output logic [2:0]       residue
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
  typedef enum logic [1:0] {C_NONE, C_NICKEL, C_DIME, C_QUARTER} coin_t;

  state_t           state, state_n;
  coin_t            coin, coin_n;
  logic [AMT_W-1:0] rem, rem_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       residue_r, residue_n;

  function automatic logic [AMT_W-1:0] coin_value(input coin_t c);
    logic [AMT_W-1:0] v;
    case (c)
      C_QUARTER: v = AMT_W'(25);
      C_DIME:    v = AMT_W'(10);
      C_NICKEL:  v = AMT_W'(5);
      default:   v = '0;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      coin      <= C_NONE;
      rem       <= '0;
      cnt       <= '0;
      residue_r <= '0;
    end else begin
      state     <= state_n;
      coin      <= coin_n;
      rem       <= rem_n;
      cnt       <= cnt_n;
      residue_r <= residue_n;
    end
  end

  always_comb begin
    state_n   = state;
    coin_n    = coin;
    rem_n     = rem;
    cnt_n     = cnt;
    residue_n = residue_r;
    case (state)
      IDLE: begin
        if (start) begin
          rem_n     = amount;
          residue_n = '0;
          state_n   = SELECT;
        end
      end
      SELECT: begin
        cnt_n = '0;
        if (rem >= AMT_W'(25)) begin
          coin_n  = C_QUARTER;
          state_n = PULSE;
        end else if (rem >= AMT_W'(10)) begin
          coin_n  = C_DIME;
          state_n = PULSE;
        end else if (rem >= AMT_W'(5)) begin
          coin_n  = C_NICKEL;
          state_n = PULSE;
        end else begin
          coin_n    = C_NONE;
          residue_n = rem[2:0];
          state_n   = DONE;
        end
      end
      PULSE: begin
        // Coin value was checked against rem in SELECT, so this cannot underflow.
        if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
          rem_n   = rem - coin_value(coin);
          cnt_n   = '0;
          state_n = GAP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = SELECT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Cancel overrides every busy-state transition; a truncated payout reports no residue.
    if (abort && state != IDLE) begin
      state_n   = IDLE;
      coin_n    = C_NONE;
      cnt_n     = '0;
      residue_n = '0;
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign quarter = (state == PULSE) && (coin == C_QUARTER);
  assign dime    = (state == PULSE) && (coin == C_DIME);
  assign nickel  = (state == PULSE) && (coin == C_NICKEL);
  assign residue = residue_r;

endmodule
